// File: rtl/reg8_pkg.sv
// rtl/reg8_pkg.sv - shared state encodings and sizing constants for reg8_loader (REG8_LOADER_PARITY_EN adds PAR)
package reg8_pkg;

    localparam int DATA_W_DEF = 8;

    // Count must reach DATA_W, so it needs one value beyond DATA_W-1.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DATA_W_DEF);

`ifdef REG8_LOADER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        WRITE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/reg8_deser.sv
// rtl/reg8_deser.sv - serial-to-parallel shift register with accepted-bit counter
module reg8_deser
    import reg8_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MSB_FIRST = 1,
    parameter int CW        = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              res,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] word,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] word_next;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign word_next = {word[DATA_W-2:0], ser_in};
        end else begin : g_lsb
            assign word_next = {ser_in, word[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (res || clr) begin
            word  <= '0;
            count <= '0;
        end else if (shift_en) begin
            word  <= word_next;
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/reg8_loader.sv
// rtl/reg8_loader.sv - serial frame loader driving a parallel register write port (optional REG8_LOADER_PARITY_EN)
module reg8_loader
    import reg8_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic              busy,
    output logic              reg_en,
    output logic [DATA_W-1:0] reg_data
`ifdef REG8_LOADER_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int CW = cnt_w(DATA_W);

    state_t            state, state_next;
    logic              clr, shift_en;
    logic [DATA_W-1:0] word;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] reg_data_q;
`ifdef REG8_LOADER_PARITY_EN
    logic              par_fail;
`endif

    reg8_deser #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_deser (
        .clk      (clk),
        .res      (res),
        .clr      (clr),
        .shift_en (shift_en),
        .ser_in   (ser_in),
        .word     (word),
        .count    (count)
    );

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        shift_en   = 1'b0;
`ifdef REG8_LOADER_PARITY_EN
        par_fail   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    clr        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    clr = 1'b1;
                end else if (ser_valid) begin
                    shift_en = 1'b1;
                    if (count == CW'(DATA_W - 1)) begin
`ifdef REG8_LOADER_PARITY_EN
                        state_next = PAR;
`else
                        state_next = WRITE;
`endif
                    end
                end
            end
`ifdef REG8_LOADER_PARITY_EN
            PAR: begin
                if (start) begin
                    clr        = 1'b1;
                    state_next = SHIFT;
                end else if (ser_valid) begin
                    // Even parity: data ones plus parity bit must total an even count.
                    if (ser_in == ^word) begin
                        state_next = WRITE;
                    end else begin
                        state_next = IDLE;
                        par_fail   = 1'b1;
                    end
                end
            end
`endif
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            reg_en     <= 1'b0;
            reg_data_q <= '0;
        end else begin
            state  <= state_next;
            reg_en <= (state_next == WRITE);
            if (state == WRITE) begin
                reg_data_q <= word;
            end
        end
    end

`ifdef REG8_LOADER_PARITY_EN
    always_ff @(posedge clk) begin
        if (res || clr) begin
            parity_err <= 1'b0;
        end else if (par_fail) begin
            parity_err <= 1'b1;
        end
    end
`endif

    // The assembled word is presented during WRITE and held afterwards.
    assign reg_data = (state == WRITE) ? word : reg_data_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_reg8_loader.sv
// tb/tb_reg8_loader.sv - directed vector bench for reg8_loader (REG8_LOADER_PARITY_EN adds parity cases)
module tb_reg8_loader;

    logic       clk;
    logic       res;
    logic       start;
    logic       ser_in;
    logic       ser_valid;
    logic       busy;
    logic       reg_en;
    logic [7:0] reg_data;
`ifdef REG8_LOADER_PARITY_EN
    logic       parity_err;
`endif

    int         n_vec;
    int         n_err;
    int         wr_cnt;
    int         w0;
    logic [7:0] ds_q;

    reg8_loader #(
        .DATA_W    (8),
        .MSB_FIRST (1)
    ) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .busy      (busy),
        .reg_en    (reg_en),
        .reg_data  (reg_data)
`ifdef REG8_LOADER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register fed by EN/Reg_In, plus a write counter.
    always @(posedge clk) begin
        if (res) begin
            ds_q <= 8'h00;
        end else if (reg_en) begin
            ds_q <= reg_data;
        end
    end

    always @(negedge clk) begin
        if (reg_en) wr_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         gaps;
        bit         sv_with_start;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic b);
        start     = s;
        ser_valid = v;
        ser_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit gaps, input bit sv_start, input bit par_ok);
        step(1'b1, sv_start, 1'b1);
        chk("busy_after_start", busy, 1);
`ifdef REG8_LOADER_PARITY_EN
        chk("perr_clr_on_start", parity_err, 0);
`endif
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, d[i]);
            if (gaps && i > 0) repeat ((i % 3) + 1) step(1'b0, 1'b0, 1'b0);
        end
`ifdef REG8_LOADER_PARITY_EN
        step(1'b0, 1'b1, par_ok ? ^d : ~^d);
`else
        if (!par_ok) chk("par_ok_unused", 0, 1);
`endif
    endtask

    task automatic expect_write(input logic [7:0] d);
        chk("reg_en_on_write", reg_en, 1);
        chk("reg_data_on_write", reg_data, d);
        step(1'b0, 1'b0, 1'b0);
        chk("reg_en_after_write", reg_en, 0);
        chk("busy_after_write", busy, 0);
        chk("reg_data_hold", reg_data, d);
    endtask

    initial begin
        n_vec = 0; n_err = 0; wr_cnt = 0;
        start = 0; ser_valid = 0; ser_in = 0;

        tbl[0] = '{8'h77, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'h01, 1'b1, 1'b1};

        res = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        res = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_reg_data", reg_data, 8'h00);
`ifdef REG8_LOADER_PARITY_EN
        chk("rst_parity_err", parity_err, 0);
`endif

        // Reset mid-frame after 5 bits: no write, word discarded.
        w0 = wr_cnt;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        chk("midframe_busy", busy, 1);
        res = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        res = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_reg_en", reg_en, 0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);
        chk("idle_ignores_bits", busy, 0);
        chk("midrst_reg_data", reg_data, 8'h00);
        chk("midrst_writes", wr_cnt - w0, 0);

        for (int k = 0; k < 6; k++) begin
            w0 = wr_cnt;
            send_frame(tbl[k].data, tbl[k].gaps, tbl[k].sv_with_start, 1'b1);
            expect_write(tbl[k].data);
            chk("write_count", wr_cnt - w0, 1);
            chk("downstream_q", ds_q, tbl[k].data);
        end

        // Abort after 3 bits; restart carries a bit that must be dropped.
        w0 = wr_cnt;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        chk("hold_during_frame", reg_data, 8'h01);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        expect_write(8'h3C);
        chk("abort_write_count", wr_cnt - w0, 1);

        // start during WRITE is ignored.
        w0 = wr_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("wr_start_reg_en", reg_en, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("wr_start_ignored", busy, 0);
        chk("wr_start_reg_en_low", reg_en, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("wr_start_write_count", wr_cnt - w0, 1);
        chk("wr_start_data", reg_data, 8'h5A);

`ifdef REG8_LOADER_PARITY_EN
        w0 = wr_cnt;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        chk("bad_par_reg_en", reg_en, 0);
        chk("bad_par_busy", busy, 0);
        chk("bad_par_err", parity_err, 1);
        step(1'b0, 1'b1, 1'b0);
        chk("bad_par_sticky", parity_err, 1);
        chk("bad_par_no_write", wr_cnt - w0, 0);
        chk("bad_par_data_kept", reg_data, 8'h5A);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        expect_write(8'h77);
        chk("good_par_err", parity_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg8_loader.md
REG8_LOADER -- requirements
Module: reg8_loader

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the assembled word and the register write port.
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the serial bit order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 res  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  SHALL be the frame start strobe.
REQ-006 ser_in  input  1  SHALL be the serial data bit.
REQ-007 ser_valid  input  1  SHALL qualify ser_in for one clock.
REQ-008 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-009 reg_en  output  1  SHALL be the register write-enable strobe; it drives the EN input of the downstream 8-bit register.
REQ-010 reg_data  output  DATA_W  SHALL be the register write data; it drives Reg_In of the downstream register.
REQ-011 parity_err  output  1  SHALL be the sticky parity-error flag; it is present only with PARITY_EN (see REQ-024).

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, PAR (PARITY_EN only) and WRITE.
REQ-013 IDLE: start=1 SHALL move the FSM to SHIFT with the bit count cleared to 0; ser_valid SHALL be ignored in IDLE, including a ser_valid in the same cycle as start.
REQ-014 SHIFT: each cycle with ser_valid=1 SHALL capture ser_in into the shift register (in the order set by MSB_FIRST) and increment the count; cycles with ser_valid=0 SHALL hold all state.
REQ-015 On acceptance of bit DATA_W-1, the FSM SHALL go to WRITE, or to PAR when PARITY_EN is defined.
REQ-016 start=1 in SHIFT or PAR SHALL abort the frame, clear the count and stay in (or return to) SHIFT; a bit presented in that same cycle SHALL be discarded.
REQ-017 WRITE: reg_en SHALL be 1 for exactly one cycle, and reg_data SHALL equal the assembled word in that cycle; the next state SHALL be IDLE, and start in WRITE SHALL be ignored.
REQ-018 Latency: reg_en SHALL assert in the cycle after the last data bit (or the parity bit) is accepted.
REQ-019 reg_data SHALL hold its last written value until the next WRITE.
REQ-020 reg_en SHALL never be high outside WRITE; at most one write SHALL occur per frame.

Reset
REQ-021 res=1 SHALL, at the next rising edge, force state=IDLE, count=0, shift register=0, reg_en=0, reg_data=0 and parity_err=0.
REQ-022 res SHALL take priority over start and ser_valid; asserting res mid-frame SHALL discard the partial word and produce no write.

Configuration
REQ-023 Macro REG8_LOADER_PARITY_EN SHALL select whether the parity check is compiled in.
REQ-024 Defined: after the DATA_W data bits, PAR SHALL accept one even-parity bit on the next ser_valid.
- Correct parity -> WRITE.
- Incorrect parity -> IDLE with no write, and parity_err set; parity_err stays set until the next start or res.
REQ-025 Undefined: the PAR state and the parity_err port SHALL NOT exist, and SHIFT SHALL go directly to WRITE.

Structure
REQ-026 The shared package/include reg8_pkg SHALL hold the FSM state encodings, DATA_W default and the bit-count width constant.
REQ-027 The shift register plus bit counter SHALL be one sub-module, reg8_deser, with ports clk, res, clr, shift_en, ser_in, word and count.
REQ-028 The top level SHALL contain only the FSM and the output registers.

Verification
REQ-029 Reset: res=1 for 2 cycles -> busy=0, reg_en=0, reg_data=8'h00, parity_err=0.
REQ-030 Basic write: start, then 8 consecutive valid bits of 8'h77 MSB-first -> reg_en=1 for exactly one cycle, one cycle after the 8th bit; reg_data=8'h77; busy=0 the next cycle.
REQ-031 Gaps: 8'hA5 with ser_valid=0 gaps of 1-3 cycles between bits -> single write of 8'hA5; the downstream register output equals 8'hA5 afterwards.
REQ-032 Abort: start, 3 bits, start again, then 8'h3C -> exactly one write, of 8'h3C.
REQ-033 Reset mid-frame: res=1 after 5 bits -> no reg_en; IDLE; reg_data keeps 8'h00.
REQ-034 Parity, PARITY_EN defined: 8'h77 with parity bit 1 (wrong) -> no write, parity_err=1; then 8'h77 with parity 0 -> reg_data=8'h77, parity_err cleared at start.
